// File: rtl/iq_dequant.sv
// Inverse-quantisation front end: streams 64 coefficients per 8x8 block, addresses the
// quantiser-step ROM and emits saturated products over a valid/ready handshake.
module iq_dequant #(
  parameter  int COEF_W  = 12,
  parameter  int Q_W     = 8,
  parameter  int BLOCK_N = 64,
  localparam int IDX_W   = $clog2(BLOCK_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] in_coeff,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IDX_W-1:0]  romq_a,
  input  logic [Q_W-1:0]    romq_d,
  output logic [COEF_W-1:0] out_coeff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_sat,
  output logic              busy
);

  localparam int P_W = COEF_W + Q_W + 1;
  localparam logic signed [P_W-1:0]  MAX_P   = P_W'(2 ** (COEF_W - 1) - 1);
  localparam logic signed [P_W-1:0]  MIN_P   = ~MAX_P;
  localparam logic [COEF_W-1:0]      OUT_MAX = {1'b0, {(COEF_W - 1){1'b1}}};
  localparam logic [COEF_W-1:0]      OUT_MIN = {1'b1, {(COEF_W - 1){1'b0}}};
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BLOCK_N - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [COEF_W-1:0]   s1_coeff_q, s2_coeff_q;
  logic [IDX_W-1:0]    s1_idx_q, s2_idx_q;
  logic                s1_valid_q, s2_valid_q;
  logic [COEF_W-1:0]   out_coeff_q;
  logic                out_valid_q, out_last_q, out_sat_q;

  logic                adv, in_acc, out_acc;
  logic signed [P_W-1:0] prod;
  logic [COEF_W-1:0]   sat_coeff;
  logic                sat_flag;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign in_acc   = in_valid && adv;
  assign out_acc  = out_valid_q && out_ready;

  // While stalled the ROM keeps being addressed with the S2 index so its registered
  // output still matches the coefficient waiting in S2.
  assign romq_a = adv ? s1_idx_q : s2_idx_q;

  assign prod = P_W'($signed(s2_coeff_q)) * P_W'($signed({1'b0, romq_d}));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sat_coeff = prod[COEF_W-1:0];
    sat_flag  = 1'b0;
    if (prod > MAX_P) begin
      sat_coeff = OUT_MAX;
      sat_flag  = 1'b1;
    end else if (prod < MIN_P) begin
      sat_coeff = OUT_MIN;
      sat_flag  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values and the stages shift together without ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      s1_coeff_q  <= '0;
      s1_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      s2_coeff_q  <= '0;
      s2_idx_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_coeff_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_acc;
      if (in_acc) begin
        s1_coeff_q <= in_coeff;
        s1_idx_q   <= idx_q;
        idx_q      <= idx_q + IDX_W'(1);
      end
      s2_coeff_q  <= s1_coeff_q;
      s2_idx_q    <= s1_idx_q;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_coeff_q <= sat_coeff;
        out_sat_q   <= sat_flag;
        out_last_q  <= (s2_idx_q == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q == ACTIVE);
    case (state_q)
      IDLE:   if (in_acc) state_d = ACTIVE;
      // Coefficients of a following block already in the pipeline keep the block busy.
      ACTIVE: if (out_acc && out_last_q && !in_acc && !s1_valid_q && !s2_valid_q)
                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_coeff = out_coeff_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_iq_dequant.sv
// Randomised bench for iq_dequant: a queue-based reference model predicts every output
// from the accepted coefficients and the JPEG luminance step table.
module tb_iq_dequant;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_coeff;
  logic        in_valid, in_ready;
  logic [5:0]  romq_a;
  logic [7:0]  romq_d = 8'd0;
  logic [11:0] out_coeff;
  logic        out_valid, out_ready, out_last, out_sat, busy;

  iq_dequant dut (
    .clk(clk), .rst(rst), .in_coeff(in_coeff), .in_valid(in_valid), .in_ready(in_ready),
    .romq_a(romq_a), .romq_d(romq_d), .out_coeff(out_coeff), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int rom[64] = '{16, 11, 10, 16, 24, 40, 51, 61,
                  12, 12, 14, 19, 26, 58, 60, 55,
                  14, 13, 16, 24, 40, 57, 69, 56,
                  14, 17, 22, 29, 51, 87, 80, 62,
                  18, 22, 37, 56, 68, 109, 103, 77,
                  24, 35, 55, 64, 81, 104, 113, 92,
                  49, 64, 78, 87, 103, 121, 120, 101,
                  72, 92, 95, 98, 112, 100, 103, 99};

  always @(posedge clk) romq_d <= 8'(rom[romq_a]);

  typedef struct {
    int val;
    bit sat;
    bit last;
    int idx;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0, n_fail = 0;
  int   m_idx = 0, cyc = 0, n_acc = 0, n_out = 0, n_last = 0;
  int   first_acc_cyc = -1, first_out_cyc = -1;
  int   got_val[64];
  bit   got_sat[64], got_last[64];
  logic s_in_ready, s_busy;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [11:0] c);
    exp_t e;
    int   p;
    p      = int'($signed(c)) * rom[m_idx];
    e.idx  = m_idx;
    e.last = (m_idx == 63);
    if (p > 2047)       begin e.val = 2047;  e.sat = 1'b1; end
    else if (p < -2048) begin e.val = -2048; e.sat = 1'b1; end
    else                begin e.val = p;     e.sat = 1'b0; end
    expq.push_back(e);
    m_idx = (m_idx + 1) % 64;
  endtask

  // Drive one cycle's inputs, then observe both handshakes before the next rising edge.
  task automatic cycle(input bit iv, input logic [11:0] ic, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_coeff  = ic;
    out_ready = ordy;
    #1;
    cyc++;
    s_in_ready = in_ready;
    s_busy     = busy;
    if (in_valid && in_ready) begin
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      model_push(in_coeff);
      n_acc++;
    end
    if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = expq.pop_front();
        check("coeff", int'($signed(out_coeff)), e.val);
        check("sat", int'(out_sat), int'(e.sat));
        check("last", int'(out_last), int'(e.last));
        got_val[e.idx]  = int'($signed(out_coeff));
        got_sat[e.idx]  = out_sat;
        got_last[e.idx] = out_last;
      end
      n_out++;
      if (out_last) n_last++;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (expq.size() > 0 && guard < 300) begin
      cycle(1'b0, 12'd0, 1'b1);
      guard++;
    end
    if (expq.size() > 0) check("drain_timeout", expq.size(), 0);
  endtask

  task automatic feed(input int count, input bit ordy);
    int target = n_acc + count;
    int guard  = 0;
    while (n_acc < target && guard < 1000) begin
      cycle(1'b1, 12'($urandom_range(0, 4095)), ordy);
      guard++;
    end
    if (n_acc < target) check("feed_timeout", n_acc, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_out, base_last, target, guard;

    rst = 1'b1; in_valid = 1'b0; in_coeff = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_coeff", int'(out_coeff), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_sat", int'(out_sat), 0);

    // All-ones block: outputs are the step table itself.
    n_last = 0;
    for (int i = 0; i < 64; i++) cycle(1'b1, 12'd1, 1'b1);
    cycle(1'b0, 12'd0, 1'b1);
    check("busy_mid_block", int'(s_busy), 1);
    drain();
    cycle(1'b0, 12'd0, 1'b1);
    check("busy_after_last", int'(s_busy), 0);
    check("latency", first_out_cyc - first_acc_cyc, 3);
    check("ones_n_last", n_last, 1);
    check("ones_out0", got_val[0], 16);
    check("ones_out1", got_val[1], 11);
    check("ones_out63", got_val[63], 99);
    check("ones_last62", int'(got_last[62]), 0);
    check("ones_last63", int'(got_last[63]), 1);

    // Saturation, negative values, zero coefficient and the final index.
    cycle(1'b1, 12'd200, 1'b1);
    cycle(1'b1, 12'hFFB, 1'b1);
    cycle(1'b1, 12'd0, 1'b1);
    for (int i = 3; i < 63; i++) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b1);
    cycle(1'b1, 12'd1, 1'b1);
    drain();
    check("pos_clip_val", got_val[0], 2047);
    check("pos_clip_sat", int'(got_sat[0]), 1);
    check("neg5_val", got_val[1], -55);
    check("neg5_sat", int'(got_sat[1]), 0);
    check("zero_val", got_val[2], 0);
    check("zero_sat", int'(got_sat[2]), 0);
    check("idx63_val", got_val[63], 99);
    check("idx63_last", int'(got_last[63]), 1);

    cycle(1'b1, 12'hF38, 1'b1);
    feed(63, 1'b1);
    drain();
    check("neg_clip_val", got_val[0], -2048);
    check("neg_clip_sat", int'(got_sat[0]), 1);

    // Downstream stall mid-block while input stays valid.
    base_out = n_out;
    feed(10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
      check("stall_in_ready", int'(s_in_ready), 0);
    end
    feed(54, 1'b1);
    drain();
    check("stall_block_outputs", n_out - base_out, 64);

    // Three back-to-back blocks with random gaps on both sides.
    base_out  = n_out;
    base_last = n_last;
    target    = n_acc + 192;
    guard     = 0;
    while (n_acc < target && guard < 5000) begin
      cycle($urandom_range(0, 9) < 7, 12'($urandom_range(0, 4095)), $urandom_range(0, 9) < 7);
      guard++;
    end
    check("random_accepts", n_acc, target);
    guard = 0;
    while (expq.size() > 0 && guard < 1000) begin
      cycle(1'b0, 12'd0, $urandom_range(0, 9) < 7);
      guard++;
    end
    check("random_drained", expq.size(), 0);
    check("random_outputs", n_out - base_out, 192);
    check("random_lasts", n_last - base_last, 3);

    // Asynchronous reset in the middle of a block.
    feed(20, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check("pre_rst_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    expq.delete();
    m_idx = 0;
    got_val[0] = -99999;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 12'd1, 1'b1);
    feed(63, 1'b1);
    drain();
    check("post_rst_out0", got_val[0], 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
